// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the core's load/store path.
// One request at a time. Loads get byte-lane extraction plus sign/zero extension.
// Sub-word stores do a read-modify-write on an internal synchronous word RAM.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned accesses with
// resp_err instead of serving them.
module data_mem_responder #(
  parameter int ADDR_W    = 8,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int WORDS = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-3:0] r_idx;
  logic [1:0]        r_off;
  logic [1:0]        r_size;
  logic              r_we;
  logic              r_unsigned;
  logic              r_err;
  logic [31:0]       r_wdata;
  logic [31:0]       r_ram_q;
  logic [31:0]       r_rdata_hold;
  logic              r_err_hold;

  logic              w_accept;
  logic              w_req_err;
  logic              w_ram_we;
  logic [4:0]        w_shamt;
  logic [15:0]       w_lo;
  logic [31:0]       w_load_data;
  logic [31:0]       w_mask;
  logic [31:0]       w_wr_word;
  logic [31:0]       w_resp_rdata;

  logic [31:0] r_mem [WORDS] = '{default: ((INIT_ZERO != 0) ? 32'h0 : 32'hx)};

  assign w_accept = req_valid && (r_state == IDLE) && !reset;
  assign w_shamt  = {r_off, 3'b000};
  assign w_ram_we = (r_state == WRITE) && !reset;

  // Classify an incoming request as rejected (no RAM access at all).
  always_comb begin
    w_req_err = (req_size == 2'd3);
`ifdef MISALIGN_TRAP_EN
    if ((req_size == 2'd0) && (req_addr[1:0] != 2'd0)) w_req_err = 1'b1;
    if ((req_size == 2'd2) && (req_addr[1:0] == 2'd3)) w_req_err = 1'b1;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: SW skips the read, sub-word stores read then write.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_err)                       w_next = RESP;
          else if (req_we && req_size == 2'd0) w_next = WRITE;
          else                                 w_next = READ;
        end
      end
      READ:    w_next = r_we ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latch every request field at the accept edge.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx      <= req_addr[ADDR_W-1:2];
      r_off      <= req_addr[1:0];
      r_size     <= req_size;
      r_we       <= req_we;
      r_unsigned <= req_unsigned;
      r_err      <= w_req_err;
      r_wdata    <= req_wdata;
    end
  end

  // Word RAM: registered read in READ, write at the edge leaving WRITE.
  always_ff @(posedge clk) begin
    if (w_ram_we)         r_mem[r_idx] <= w_wr_word;
    if (r_state == READ)  r_ram_q      <= r_mem[r_idx];
  end

  // Load extraction and store merge from the registered RAM word.
  // Shifting the lane into bit 0 makes a half at offset 3 see zero in its upper
  // byte, and shifting the mask drops the out-of-word lane of such a store.
  always_comb begin
    w_lo   = 16'(r_ram_q >> w_shamt);
    case (r_size)
      2'd1:    w_load_data = {{24{~r_unsigned & w_lo[7]}}, w_lo[7:0]};
      2'd2:    w_load_data = {{16{~r_unsigned & w_lo[15]}}, w_lo};
      default: w_load_data = r_ram_q;
    endcase
    w_mask = ((r_size == 2'd1) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
    if (r_size == 2'd0) w_wr_word = r_wdata;
    else                w_wr_word = (r_ram_q & ~w_mask) | ((r_wdata << w_shamt) & w_mask);
    w_resp_rdata = (!r_we && !r_err) ? w_load_data : '0;
  end

  // Keep the last response visible until the next RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata_hold <= '0;
      r_err_hold   <= 1'b0;
    end else if (r_state == RESP) begin
      r_rdata_hold <= w_resp_rdata;
      r_err_hold   <= r_err;
    end
  end

  // Output decode.
  always_comb begin
    req_ready  = (r_state == IDLE) && !reset;
    resp_valid = (r_state == RESP);
    resp_rdata = (r_state == RESP) ? w_resp_rdata : r_rdata_hold;
    resp_err   = (r_state == RESP) ? r_err : r_err_hold;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed vector table, reset-abort sequence,
// and randomized requests against a byte-addressed reference model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] mb [256];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt [22];

  data_mem_responder #(.ADDR_W(8), .INIT_ZERO(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: memory as bytes, requests evaluated straight from the access rules.
  function automatic void model_req(input logic we, input logic [1:0] size, input logic uns,
                                    input logic [7:0] addr, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic er, output int lat);
    int base = int'(addr) & 32'hFC;
    int off  = int'(addr) % 4;
    int nb;
    logic [31:0] v;
    rd = '0; er = 1'b0; lat = 1;
    if (size == 2'd3) begin er = 1'b1; return; end
`ifdef MISALIGN_TRAP_EN
    if ((size == 2'd0 && off != 0) || (size == 2'd2 && off == 3)) begin er = 1'b1; return; end
`endif
    nb = (size == 2'd0) ? 4 : (size == 2'd1) ? 1 : 2;
    if (we) begin
      if (size == 2'd0) begin
        for (int i = 0; i < 4; i++) mb[base + i] = wd[8*i +: 8];
        lat = 2;
      end else begin
        for (int i = 0; i < nb; i++) if (off + i < 4) mb[int'(addr) + i] = wd[8*i +: 8];
        lat = 3;
      end
    end else begin
      lat = 2;
      v = '0;
      if (size == 2'd0) begin
        for (int i = 0; i < 4; i++) v[8*i +: 8] = mb[base + i];
      end else begin
        for (int i = 0; i < nb; i++) if (off + i < 4) v[8*i +: 8] = mb[int'(addr) + i];
        if (!uns && v[8*nb - 1]) for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      rd = v;
    end
  endfunction

  // Wait (bounded) for ready, present one request, return just after the accept edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [7:0] addr, input logic [31:0] wd);
    int waitc = 0;
    @(negedge clk);
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) chk("ready_timeout", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = 8'($urandom); req_wdata = $urandom;
  endtask

  // Full transaction: measure latency, capture response, then check it is held.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [7:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    logic got = 1'b0;
    rd = '0; er = 1'b0; lat = 0;
    issue(we, size, uns, addr, wd);
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1; lat = c; rd = resp_rdata; er = resp_err;
      end
    end
    if (got) begin
      @(negedge clk);
      chk("pulse_one_cycle", {31'b0, resp_valid}, 32'd0);
      chk("ready_after_resp", {31'b0, req_ready}, 32'd1);
      chk("rdata_held", resp_rdata, rd);
      chk("err_held", {31'b0, resp_err}, {31'b0, er});
    end
  endtask

  initial begin
    logic [31:0] rd, mrd;
    logic        er, mer;
    int          lat, mlat;
    logic [1:0]  sz;
    int          s;

    for (int i = 0; i < 256; i++) mb[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'b0, req_ready}, 32'd0);
    chk("reset_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset_rdata", resp_rdata, 32'd0);
    chk("reset_err", {31'b0, resp_err}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    //            we    size  uns   addr   wdata          exp_rd         err   lat
    vt[0]  = '{1'b1, 2'd0, 1'b0, 8'h10, 32'h8899AABB, 32'h00000000, 1'b0, 2};
    vt[1]  = '{1'b0, 2'd0, 1'b0, 8'h10, 32'h0,        32'h8899AABB, 1'b0, 2};
    vt[2]  = '{1'b1, 2'd1, 1'b0, 8'h12, 32'h000000C3, 32'h00000000, 1'b0, 3};
    vt[3]  = '{1'b0, 2'd0, 1'b0, 8'h10, 32'h0,        32'h88C3AABB, 1'b0, 2};
    vt[4]  = '{1'b0, 2'd1, 1'b0, 8'h12, 32'h0,        32'hFFFFFFC3, 1'b0, 2};
    vt[5]  = '{1'b0, 2'd1, 1'b1, 8'h12, 32'h0,        32'h000000C3, 1'b0, 2};
    vt[6]  = '{1'b1, 2'd2, 1'b0, 8'h10, 32'h12347F00, 32'h00000000, 1'b0, 3};
    vt[7]  = '{1'b0, 2'd2, 1'b0, 8'h10, 32'h0,        32'h00007F00, 1'b0, 2};
    vt[8]  = '{1'b0, 2'd0, 1'b0, 8'h10, 32'h0,        32'h88C37F00, 1'b0, 2};
    vt[9]  = '{1'b0, 2'd2, 1'b0, 8'h12, 32'h0,        32'hFFFF88C3, 1'b0, 2};
    vt[10] = '{1'b1, 2'd0, 1'b0, 8'h14, 32'h80FFFFFF, 32'h00000000, 1'b0, 2};
    vt[16] = '{1'b1, 2'd0, 1'b0, 8'h20, 32'hCAFEF00D, 32'h00000000, 1'b0, 2};
    vt[17] = '{1'b1, 2'd3, 1'b0, 8'h20, 32'h11111111, 32'h00000000, 1'b1, 1};
    vt[18] = '{1'b0, 2'd0, 1'b0, 8'h20, 32'h0,        32'hCAFEF00D, 1'b0, 2};
    vt[19] = '{1'b0, 2'd3, 1'b0, 8'h04, 32'h0,        32'h00000000, 1'b1, 1};
    vt[20] = '{1'b0, 2'd1, 1'b1, 8'h23, 32'h0,        32'h000000CA, 1'b0, 2};
    vt[21] = '{1'b0, 2'd2, 1'b0, 8'h21, 32'h0,        32'hFFFFFEF0, 1'b0, 2};
`ifdef MISALIGN_TRAP_EN
    vt[11] = '{1'b0, 2'd2, 1'b0, 8'h17, 32'h0,        32'h00000000, 1'b1, 1};
    vt[12] = '{1'b1, 2'd2, 1'b0, 8'h17, 32'h00001234, 32'h00000000, 1'b1, 1};
    vt[13] = '{1'b0, 2'd0, 1'b0, 8'h14, 32'h0,        32'h80FFFFFF, 1'b0, 2};
    vt[14] = '{1'b0, 2'd1, 1'b0, 8'h17, 32'h0,        32'hFFFFFF80, 1'b0, 2};
    vt[15] = '{1'b0, 2'd0, 1'b0, 8'h11, 32'h0,        32'h00000000, 1'b1, 1};
`else
    vt[11] = '{1'b0, 2'd2, 1'b0, 8'h17, 32'h0,        32'h00000080, 1'b0, 2};
    vt[12] = '{1'b1, 2'd2, 1'b0, 8'h17, 32'h00001234, 32'h00000000, 1'b0, 3};
    vt[13] = '{1'b0, 2'd0, 1'b0, 8'h14, 32'h0,        32'h34FFFFFF, 1'b0, 2};
    vt[14] = '{1'b0, 2'd1, 1'b0, 8'h17, 32'h0,        32'h00000034, 1'b0, 2};
    vt[15] = '{1'b0, 2'd0, 1'b0, 8'h11, 32'h0,        32'h88C37F00, 1'b0, 2};
`endif

    foreach (vt[i]) begin
      do_req(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, rd, er, lat);
      model_req(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, mrd, mer, mlat);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vt[i].exp_err});
      chk($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
    end

    // Reset while an SB sits in WRITE: the write is dropped and no response appears.
    do_req(1'b1, 2'd0, 1'b0, 8'h30, 32'h01020304, rd, er, lat);
    void'(model_req(1'b1, 2'd0, 1'b0, 8'h30, 32'h01020304, mrd, mer, mlat));
    issue(1'b1, 2'd1, 1'b0, 8'h30, 32'h000000EE);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_after_ready", {31'b0, req_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      chk("rst_no_resp", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    do_req(1'b0, 2'd0, 1'b0, 8'h30, 32'h0, rd, er, lat);
    chk("rst_word_kept", rd, 32'h01020304);

    // Randomized traffic checked against the byte model.
    for (int n = 0; n < 150; n++) begin
      logic        we, uns;
      logic [7:0]  a;
      logic [31:0] wd;
      s   = int'($urandom_range(0, 9));
      sz  = (s < 3) ? 2'd0 : (s < 6) ? 2'd1 : (s < 9) ? 2'd2 : 2'd3;
      we  = 1'($urandom);
      uns = 1'($urandom);
      a   = 8'($urandom_range(0, 63));
      wd  = $urandom;
      do_req(we, sz, uns, a, wd, rd, er, lat);
      model_req(we, sz, uns, a, wd, mrd, mer, mlat);
      chk($sformatf("rnd%0d_rdata", n), rd, mrd);
      chk($sformatf("rnd%0d_err", n), {31'b0, er}, {31'b0, mer});
      chk($sformatf("rnd%0d_lat", n), lat, mlat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's load/store path.
- Accepts one request at a time: byte address, size, signedness and store data.
- Loads: does the byte-lane extraction and sign/zero extension internally, then returns the result.
- Sub-word stores: does a read-modify-write on an internal word-wide synchronous RAM, so the core only supplies raw store data.

Parameters:
ADDR_W, 8, byte-address width; RAM holds 2**(ADDR_W-2) 32-bit words
INIT_ZERO, 1, 1 = RAM preset to zero at elaboration; 0 = contents undefined

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE, low while reset is high)
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = word, 1 = byte, 2 = halfword, 3 = reserved
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0; ignored for stores
req_addr  input  ADDR_W  byte address; word index = req_addr[ADDR_W-1:2], lane = req_addr[1:0]
req_wdata  input  32  store data; byte/half taken from bits [7:0]/[15:0]
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  request rejected (no RAM write), valid with resp_valid

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - req_ready = 0 while reset is high.
  - RAM contents are not touched.
- Accept: req_valid && req_ready at a rising edge. All request fields are latched at that edge. Inputs are ignored outside IDLE.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE -> READ on accept of a load, SB or SH.
  - IDLE -> WRITE on accept of SW.
  - IDLE -> RESP on accept of size 3 or of an error request; no RAM access.
  - READ -> RESP for loads; READ -> WRITE for SB/SH.
  - WRITE -> RESP.
  - RESP -> IDLE.
- READ: RAM registered read of the latched word index; data is available in the next state.
- WRITE: RAM written at the edge leaving WRITE.
  - SW: whole req_wdata.
  - SB: the read word with only lane byte replaced by wdata[7:0].
  - SH: the read word with lanes [off, off+1] replaced by wdata[15:0].
- Load extraction:
  - word = RAM word shifted right by 8*off.
  - LB takes bits [7:0], LH takes bits [15:0].
  - The result is extended per req_unsigned.
  - LW returns the full word; the offset is ignored.
- resp_valid is high for exactly the one cycle spent in RESP. resp_rdata and resp_err are registered and held until the next RESP.
- Latency (accept edge to resp_valid cycle):
  - Loads, SW, errors: resp_valid in the 2nd cycle after accept (errors: 1st).
  - SB/SH: 3rd cycle after accept.
- Next accept is possible at the edge following RESP. Maximum one request outstanding; no response backpressure.
- Misaligned access, macro absent:
  - LH at off=3: byte3 sits in the low byte, the upper byte reads 0, then extension applies (bit15 = 0).
  - SH at off=3: writes only byte3 with wdata[7:0].
  - LW/SW at off≠0: act on the whole word.
- Reset mid-operation:
  - Returns to IDLE at that edge; no resp_valid pulse.
  - A write whose WRITE-exit edge coincides with reset high is suppressed.
- Read-after-write: a load accepted right after a store's RESP must observe the stored data. No forwarding is needed because the store has already committed.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: LH/SH with off=3 and LW/SW with off≠0 go IDLE->RESP with resp_err = 1, resp_rdata = 0 and no RAM write. Latency is the error path.
- Undefined: misaligned accesses are served as described in Behaviour; resp_err is set only for size 3.

Test Plan:
- SW addr 0x10 data 0x8899AABB, then LW 0x10 -> resp_rdata 0x8899AABB, resp_err 0; SW resp 2 cycles and LW resp 2 cycles after accept.
- After above: SB addr 0x12 data 0x000000C3 (resp at 3 cycles), then LW 0x10 -> 0x88C3AABB; LB 0x12 signed -> 0xFFFFFFC3; LB 0x12 unsigned -> 0x000000C3.
- SH addr 0x10 data 0x12347F00, then LH 0x10 signed -> 0x00007F00; LW 0x10 -> 0x88C37F00.
- Misaligned: word 0x14 = 0x80FFFFFF; LH 0x17 signed -> macro off: 0x00000080, resp_err 0; macro on: 0x00000000, resp_err 1, and a following SH 0x17 leaves the word unchanged.
- req_size 3 store to 0x20 -> resp_err 1 in the 1st cycle after accept; word 0x20 is unchanged on readback.
- Assert reset during the WRITE state of SB 0x30 -> no resp_valid, word 0x30 unchanged, req_ready high the cycle after reset drops.
